// File: rtl/regfile_banked_sb.sv
// Banked integer register file: two async read ports, execute (W) and load (L)
// write ports with size/sign extension, privilege-banked SP and load scoreboard.
module regfile_banked_sb #(
  parameter int WIDTH  = 32,
  parameter int COUNT  = 16,
  parameter int COUNTP = 4,
  parameter int SP_REG = 15,
  parameter int BYPASS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              supervisor,
  input  logic [COUNTP-1:0] rd_addr1,
  input  logic [COUNTP-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic [COUNTP-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [1:0]        wr_en,
  input  logic              wr_sext,
  input  logic [COUNTP-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic [1:0]        ld_en,
  input  logic              ld_sext,
  input  logic              ld_super,
  input  logic              sb_set,
  input  logic [COUNTP-1:0] sb_addr
);

  localparam int SW = COUNTP + 1;
  typedef logic [SW-1:0] slot_t;
  // Physical slot COUNT holds the supervisor SP; slots below it are regs[addr].
  localparam slot_t SSP_SLOT = SW'(COUNT);

  function automatic slot_t slot_of(input logic bank, input logic [COUNTP-1:0] addr);
    if (bank && (addr == COUNTP'(SP_REG)))
      return SSP_SLOT;
    return {1'b0, addr};
  endfunction

  function automatic logic in_range(input logic [COUNTP-1:0] addr);
    return ({1'b0, addr} < SSP_SLOT);
  endfunction

  function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] data,
                                              input logic [1:0] size,
                                              input logic sext);
    case (size)
      2'b01:   return {{(WIDTH-8){sext & data[7]}}, data[7:0]};
      2'b10:   return {{(WIDTH-16){sext & data[15]}}, data[15:0]};
      default: return data;
    endcase
  endfunction

  logic [WIDTH-1:0] mem [COUNT+1];
  logic [COUNT:0]   busy;

  slot_t            w_slot, l_slot, sb_slot;
  logic             w_act, l_act, sb_act;
  logic [WIDTH-1:0] w_val, l_val;

  always_comb begin
    w_slot  = slot_of(supervisor, wr_addr);
    l_slot  = slot_of(ld_super, ld_addr);
    sb_slot = slot_of(supervisor, sb_addr);
    w_act   = (wr_en != 2'b00) && in_range(wr_addr);
    l_act   = (ld_en != 2'b00) && in_range(ld_addr);
    sb_act  = sb_set && in_range(sb_addr);
    w_val   = extend(wr_data, wr_en, wr_sext);
    l_val   = extend(ld_data, ld_en, ld_sext);
  end

  // W is applied after L so it wins a same-slot collision; set after clear so
  // a back-to-back load keeps the register busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i <= COUNT; i++)
        mem[i] <= '0;
      busy <= '0;
    end else begin
      if (l_act)
        mem[l_slot] <= l_val;
      if (w_act)
        mem[w_slot] <= w_val;
      if (l_act)
        busy[l_slot] <= 1'b0;
      if (sb_act)
        busy[sb_slot] <= 1'b1;
    end
  end

  logic [COUNTP-1:0] ra [2];
  slot_t             rs [2];
  logic [WIDTH-1:0]  rd [2];
  logic              rb [2];

  assign ra[0] = rd_addr1;
  assign ra[1] = rd_addr2;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rs[p] = slot_of(supervisor, ra[p]);
      rd[p] = '0;
      rb[p] = 1'b0;
      if (in_range(ra[p])) begin
        rd[p] = mem[rs[p]];
        rb[p] = busy[rs[p]];
        if (BYPASS != 0) begin
          if (w_act && (w_slot == rs[p]))
            rd[p] = w_val;
          else if (l_act && (l_slot == rs[p]))
            rd[p] = l_val;
          if (l_act && (l_slot == rs[p]))
            rb[p] = 1'b0;
        end
      end
    end
  end

  assign rd_data1 = rd[0];
  assign rd_data2 = rd[1];
  assign rd_busy1 = rb[0];
  assign rd_busy2 = rb[1];

endmodule

// File: tb/tb_regfile_banked_sb.sv
// Directed bench for regfile_banked_sb: bypassing 16-entry instance driven from
// a vector table, plus a 12-entry registered-read instance for range/no-bypass cases.
module tb_regfile_banked_sb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        supervisor;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr, ld_addr, sb_addr;
  logic [31:0] wr_data, ld_data;
  logic [1:0]  wr_en, ld_en;
  logic        wr_sext, ld_sext, ld_super, sb_set;

  logic [31:0] d1, d2, n_d1, n_d2;
  logic        b1, b2, n_b1, n_b2;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  regfile_banked_sb #(.WIDTH(32), .COUNT(16), .COUNTP(4), .SP_REG(15), .BYPASS(1)) u_byp (
    .clk_i(clk_i), .rst_i(rst_i), .supervisor(supervisor),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1), .rd_data2(d2), .rd_busy1(b1), .rd_busy2(b2),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_sext(wr_sext),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_en(ld_en), .ld_sext(ld_sext),
    .ld_super(ld_super), .sb_set(sb_set), .sb_addr(sb_addr)
  );

  regfile_banked_sb #(.WIDTH(32), .COUNT(12), .COUNTP(4), .SP_REG(11), .BYPASS(0)) u_reg (
    .clk_i(clk_i), .rst_i(rst_i), .supervisor(supervisor),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_d1), .rd_data2(n_d2), .rd_busy1(n_b1), .rd_busy2(n_b2),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_sext(wr_sext),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_en(ld_en), .ld_sext(ld_sext),
    .ld_super(ld_super), .sb_set(sb_set), .sb_addr(sb_addr)
  );

  typedef struct {
    logic        sup;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [1:0]  we;
    logic        ws;
    logic [3:0]  la;
    logic [31:0] ldd;
    logic [1:0]  le;
    logic        ls;
    logic        lsup;
    logic        sbs;
    logic [3:0]  sba;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] ed1;
    logic        eb1;
    logic [31:0] ed2;
    logic        eb2;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_addr = 4'd0; wr_data = '0; wr_en = 2'b00; wr_sext = 1'b0;
    ld_addr = 4'd0; ld_data = '0; ld_en = 2'b00; ld_sext = 1'b0; ld_super = 1'b0;
    sb_set = 1'b0; sb_addr = 4'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // sup  wa     wd            we     ws    la     ld            le     ls    lsup  sbs   sba    ra1    ra2    ed1           eb1   ed2           eb2
    tbl[0]  = '{1'b0, 4'd3,  32'h0000_00F5, 2'b01, 1'b1, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd3,  4'd4,  32'hFFFF_FFF5, 1'b0, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 4'd3,  32'h0000_00F5, 2'b01, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd3,  4'd3,  32'h0000_00F5, 1'b0, 32'h0000_00F5, 1'b0};
    tbl[2]  = '{1'b0, 4'd3,  32'h0000_8001, 2'b10, 1'b1, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd3,  4'd3,  32'hFFFF_8001, 1'b0, 32'hFFFF_8001, 1'b0};
    tbl[3]  = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd3,  4'd0,  32'hFFFF_8001, 1'b0, 32'h0,         1'b0};
    tbl[4]  = '{1'b1, 4'd15, 32'h0000_1000, 2'b11, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 4'd3,  32'h0000_1000, 1'b0, 32'hFFFF_8001, 1'b0};
    tbl[5]  = '{1'b0, 4'd15, 32'h0000_2000, 2'b11, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 4'd3,  32'h0000_2000, 1'b0, 32'hFFFF_8001, 1'b0};
    tbl[6]  = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 4'd3,  32'h0000_2000, 1'b0, 32'hFFFF_8001, 1'b0};
    tbl[7]  = '{1'b1, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 4'd3,  32'h0000_1000, 1'b0, 32'hFFFF_8001, 1'b0};
    tbl[8]  = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b1, 4'd5,  4'd5,  4'd15, 32'h0,         1'b0, 32'h0000_2000, 1'b0};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd5,  4'd15, 32'h0,         1'b1, 32'h0000_2000, 1'b0};
    tbl[10] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd5,  32'hDEAD_BEEF, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0,  4'd5,  4'd5,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[11] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd5,  4'd5,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd7,  32'h0000_1234, 2'b11, 1'b0, 1'b0, 1'b1, 4'd7,  4'd7,  4'd7,  32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0};
    tbl[13] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd7,  4'd7,  32'h0000_1234, 1'b1, 32'h0000_1234, 1'b1};
    tbl[14] = '{1'b0, 4'd2,  32'h0000_0011, 2'b11, 1'b0, 4'd2,  32'h0000_0022, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0,  4'd2,  4'd2,  32'h0000_0011, 1'b0, 32'h0000_0011, 1'b0};
    tbl[15] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd2,  4'd7,  32'h0000_0011, 1'b0, 32'h0000_1234, 1'b1};
    tbl[16] = '{1'b1, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 4'd15, 32'h0000_1000, 1'b0, 32'h0000_1000, 1'b0};
    tbl[17] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 4'd15, 32'h0000_2000, 1'b0, 32'h0000_2000, 1'b0};
    tbl[18] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd15, 32'h0000_ABCD, 2'b11, 1'b0, 1'b1, 1'b0, 4'd0,  4'd15, 4'd15, 32'h0000_2000, 1'b1, 32'h0000_2000, 1'b1};
    tbl[19] = '{1'b1, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 4'd3,  32'h0000_ABCD, 1'b0, 32'hFFFF_8001, 1'b0};
    tbl[20] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 4'd3,  32'h0000_2000, 1'b1, 32'hFFFF_8001, 1'b0};
    tbl[21] = '{1'b0, 4'd6,  32'h0000_0080, 2'b01, 1'b1, 4'd4,  32'h1234_9ABC, 2'b10, 1'b0, 1'b0, 1'b0, 4'd0,  4'd4,  4'd6,  32'h0000_9ABC, 1'b0, 32'hFFFF_FF80, 1'b0};
    tbl[22] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd4,  4'd6,  32'h0000_9ABC, 1'b0, 32'hFFFF_FF80, 1'b0};
    tbl[23] = '{1'b0, 4'd0,  32'h0,         2'b00, 1'b0, 4'd4,  32'h0000_007F, 2'b01, 1'b1, 1'b0, 1'b0, 4'd0,  4'd4,  4'd4,  32'h0000_007F, 1'b0, 32'h0000_007F, 1'b0};
    tbl[24] = '{1'b0, 4'd4,  32'h0000_FFFF, 2'b00, 1'b1, 4'd0,  32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  4'd4,  4'd4,  32'h0000_007F, 1'b0, 32'h0000_007F, 1'b0};

    rst_i = 1'b1;
    supervisor = 1'b0;
    rd_addr1 = 4'd0;
    rd_addr2 = 4'd0;
    idle_inputs();

    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        supervisor = m[0];
        rd_addr1 = a[3:0];
        rd_addr2 = 4'(15 - a);
        #1;
        check("reset_d1", d1, 32'h0);
        check("reset_b1", {31'b0, b1}, 32'h0);
        check("reset_d2", d2, 32'h0);
        check("reset_b2", {31'b0, b2}, 32'h0);
      end
    end
    next_cycle();
    rst_i = 1'b0;

    for (int i = 0; i < NV; i++) begin
      supervisor = tbl[i].sup;
      wr_addr = tbl[i].wa;  wr_data = tbl[i].wd;   wr_en = tbl[i].we;  wr_sext = tbl[i].ws;
      ld_addr = tbl[i].la;  ld_data = tbl[i].ldd;  ld_en = tbl[i].le;  ld_sext = tbl[i].ls;
      ld_super = tbl[i].lsup;
      sb_set = tbl[i].sbs;  sb_addr = tbl[i].sba;
      rd_addr1 = tbl[i].ra1; rd_addr2 = tbl[i].ra2;
      @(negedge clk_i);
      check($sformatf("vec%0d_d1", i), d1, tbl[i].ed1);
      check($sformatf("vec%0d_b1", i), {31'b0, b1}, {31'b0, tbl[i].eb1});
      check($sformatf("vec%0d_d2", i), d2, tbl[i].ed2);
      check($sformatf("vec%0d_b2", i), {31'b0, b2}, {31'b0, tbl[i].eb2});
      next_cycle();
    end

    // Registered-read instance: no bypass, and addresses 12..15 are out of range.
    idle_inputs();
    supervisor = 1'b0;
    wr_addr = 4'd1; wr_data = 32'h0000_0077; wr_en = 2'b11;
    ld_addr = 4'd13; ld_data = 32'h0000_0055; ld_en = 2'b11;
    sb_set = 1'b1; sb_addr = 4'd13;
    rd_addr1 = 4'd1; rd_addr2 = 4'd13;
    @(negedge clk_i);
    check("nobyp_write_cycle_d1", n_d1, 32'h0);
    check("nobyp_oor_d2", n_d2, 32'h0);
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    check("nobyp_after_edge_d1", n_d1, 32'h0000_0077);
    check("nobyp_oor_d2_after", n_d2, 32'h0);
    check("nobyp_oor_b2", {31'b0, n_b2}, 32'h0);
    next_cycle();

    ld_addr = 4'd7; ld_data = 32'h0000_0033; ld_en = 2'b11;
    sb_set = 1'b1; sb_addr = 4'd8;
    rd_addr1 = 4'd7; rd_addr2 = 4'd8;
    @(negedge clk_i);
    check("nobyp_ld_cycle_b1", {31'b0, n_b1}, 32'h1);
    check("nobyp_ld_cycle_d1", n_d1, 32'h0000_1234);
    check("nobyp_set_cycle_b2", {31'b0, n_b2}, 32'h0);
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    check("nobyp_ld_done_b1", {31'b0, n_b1}, 32'h0);
    check("nobyp_ld_done_d1", n_d1, 32'h0000_0033);
    check("nobyp_set_done_b2", {31'b0, n_b2}, 32'h1);
    next_cycle();

    supervisor = 1'b1;
    wr_addr = 4'd11; wr_data = 32'h0000_0099; wr_en = 2'b11;
    rd_addr1 = 4'd11;
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    check("nobyp_ssp", n_d1, 32'h0000_0099);
    next_cycle();
    supervisor = 1'b0;
    @(negedge clk_i);
    check("nobyp_user_sp", n_d1, 32'h0);
    next_cycle();

    // Asynchronous reset in the middle of a cycle clears outputs immediately.
    supervisor = 1'b0;
    rd_addr1 = 4'd3; rd_addr2 = 4'd15;
    @(negedge clk_i);
    check("pre_rst_d1", d1, 32'hFFFF_8001);
    check("pre_rst_b2", {31'b0, b2}, 32'h1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_d1", d1, 32'h0);
    check("async_rst_d2", d2, 32'h0);
    check("async_rst_b2", {31'b0, b2}, 32'h0);
    next_cycle();
    rst_i = 1'b0;

    ld_addr = 4'd15; ld_data = 32'h0000_0042; ld_en = 2'b11; ld_super = 1'b0;
    rd_addr1 = 4'd15;
    @(negedge clk_i);
    check("post_rst_ld_byp", d1, 32'h0000_0042);
    check("post_rst_ld_busy", {31'b0, b1}, 32'h0);
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    check("post_rst_ld_reg", d1, 32'h0000_0042);
    check("post_rst_busy_reg", {31'b0, b1}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_banked_sb.md
Name: regfile_banked_sb

Overview:
Parametrised successor to the bexkat2 integer register file. It provides two async read ports and two write ports: an execute-stage port W and a load-writeback port L. Writes support size and sign extension. The stack-pointer register is banked by privilege mode. A per-register busy scoreboard tracks outstanding loads, and optional write-to-read bypass is available. It sits between decode (reads, scoreboard set) and the execute/memory writeback stages of the pipelined CPU core.

Parameters:
WIDTH, 32, data width; must be at least 16.
COUNT, 16, architectural registers per bank.
COUNTP, 4, address width; COUNT <= 2**COUNTP.
SP_REG, 15, index of the banked stack pointer.
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports and busy outputs; 0 = reads see registered state only.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
supervisor  in  1  current mode; selects the SP bank for read ports, W port and sb_set
rd_addr1, rd_addr2  in  COUNTP  read addresses
rd_data1, rd_data2  out  WIDTH  read data (combinational)
rd_busy1, rd_busy2  out  1  target has an outstanding load
wr_addr  in  COUNTP  W port address
wr_data  in  WIDTH  W port data
wr_en  in  2  W port size: 00 none, 01 byte, 10 half, 11 word
wr_sext  in  1  W port: sign-extend byte/half when 1, zero-extend when 0
ld_addr  in  COUNTP  L port address
ld_data  in  WIDTH  L port data
ld_en  in  2  L port size, same encoding as wr_en
ld_sext  in  1  L port sign-extend
ld_super  in  1  bank the load was issued under; L port uses this, not supervisor
sb_set  in  1  mark a register busy (load issued)
sb_addr  in  COUNTP  register to mark busy; bank taken from supervisor

Behaviour:
- Storage: COUNT user registers plus one supervisor SP (ssp); physical slot = ssp when bank==1 and addr==SP_REG, otherwise regs[addr].
- Busy vector: COUNT+1 bits, indexed by physical slot.
- Reset (async): all registers, ssp and busy bits = 0, so rd_data* = 0 and rd_busy* = 0 immediately.
  - Reset mid-operation discards pending loads; an ld_en arriving after reset writes normally and clears an already-clear busy bit harmlessly.
- Extension, per port:
  - 01: data[7:0], upper bits = sext ? data[7] : 0.
  - 10: data[15:0], upper bits = sext ? data[15] : 0.
  - 11: full word; sext ignored.
  - 00: no write.
- Write timing: W and L both commit on the rising clk_i edge; zero-latency registered write.
- Same-cycle W/L collision on one physical slot: W data wins.
  - The L busy-clear still applies.
  - W and L to different slots both commit.
- Read paths:
  - Physical slot for reads uses supervisor.
  - BYPASS=1: if a read slot matches an active W (or L) target this cycle, rd_data returns the extended write value, W over L. Otherwise registered value.
  - BYPASS=0: registered value only; written data is visible the cycle after the edge.
- Scoreboard:
  - sb_set sets busy[slot(supervisor, sb_addr)] at the edge.
  - ld_en != 00 clears busy[slot(ld_super, ld_addr)] at the edge.
  - Set and clear on the same slot in the same cycle: set wins (back-to-back loads).
  - W port writes do not touch busy bits.
- rd_busy:
  - BYPASS=1: busy[slot] & ~(L clearing that slot this cycle) | 0. sb_set does not affect reads in the same cycle.
  - BYPASS=0: busy[slot] registered.
- Mode switch with a load outstanding on SP: ld_super routes the data and clear to the issuing bank; the other bank is untouched.
- Address >= COUNT (when COUNT < 2**COUNTP):
  - writes ignored;
  - reads return 0;
  - rd_busy = 0;
  - sb_set ignored.

Test Plan:
- Reset, then read all addresses in both modes -> every rd_data = 0, rd_busy = 0; assert rst_i mid-run -> outputs 0 same cycle.
- W byte 0x000000F5 to r3, sext=1 then sext=0; half 0x8001 sext=1 -> r3 = 0xFFFFFFF5, 0x000000F5, then 0xFFFF8001; with BYPASS=1, rd_addr1=3 shows each value in the write cycle.
- supervisor=1 writes 0x1000 to r15, supervisor=0 writes 0x2000 to r15 -> reads of r15 return 0x1000 (super) and 0x2000 (user); other registers shared.
- sb_set r5 (user); next cycle rd_busy1=1; ld_en=11 ld_data=0xDEADBEEF ld_super=0 -> same-cycle rd_data1=0xDEADBEEF, rd_busy1=0 (BYPASS=1); next cycle busy=0.
- Same cycle: sb_set r7 and L write r7 -> r7 updated, busy[r7]=1. Same cycle: W 0x11 and L 0x22 to r2 -> r2 = 0x11.
- sb_set SP in supervisor, switch supervisor=0, L write ld_super=1 0xABCD -> ssp = 0xABCD and its busy cleared; user r15 and its busy unchanged.
